// File: rtl/axi_lite_pkg.sv
// Shared AXI-lite definitions: response codes, scheduler FSM states and
// the write/read classification of a stream beat.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Widest tkeep the classifier accepts; callers zero-extend into it.
    localparam int unsigned MAX_KEEP = 64;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DRAIN
    } state_t;

    // A beat is a write only when every tkeep byte of its real width is set.
    function automatic logic is_write(input logic [MAX_KEEP-1:0] keep,
                                      input int unsigned         width);
        logic all_set;
        all_set = 1'b1;
        for (int unsigned i = 0; i < MAX_KEEP; i++) begin
            if (i < width && !keep[i]) all_set = 1'b0;
        end
        return all_set;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester after
// last_grant, wrapping modulo N.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last_grant,
    output logic [$clog2(N)-1:0] grant,
    output logic                 any_req
);

    localparam int GW = $clog2(N);

    int unsigned w_idx;

    always_comb begin
        grant   = last_grant;
        any_req = 1'b0;
        w_idx   = 0;
        for (int unsigned i = 1; i <= N; i++) begin
            w_idx = (32'(last_grant) + i) % N;
            if (!any_req && req[GW'(w_idx)]) begin
                grant   = GW'(w_idx);
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_lite_req_scheduler.sv
// Round-robin front end for a shared axi_lite_master: one transaction in
// flight, completions snooped from B/R and returned as tagged pulses.
module axi_lite_req_scheduler
    import axi_lite_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_WD = 8,
    parameter int ADDR_WD = 8,
    parameter int BYTE_WD = (ADDR_WD + DATA_WD) >> 3,
    parameter int TIMEOUT = 255
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic [NUM_REQ*BYTE_WD-1:0]           s_tkeep,
    input  logic [NUM_REQ*(DATA_WD+ADDR_WD)-1:0] s_tdata,
    input  logic [NUM_REQ-1:0]                   s_tvalid,
    output logic [NUM_REQ-1:0]                   s_tready,
    output logic [BYTE_WD-1:0]                   m_tkeep,
    output logic [DATA_WD+ADDR_WD-1:0]           m_tdata,
    output logic                                 m_tvalid,
    input  logic                                 m_tready,
    input  logic                                 bvalid,
    input  logic                                 bready,
    input  logic [1:0]                           bresp,
    input  logic                                 rvalid,
    input  logic                                 rready,
    input  logic [DATA_WD-1:0]                   rdata,
    input  logic [1:0]                           rresp,
    output logic [NUM_REQ-1:0]                   rsp_valid,
    output logic [DATA_WD-1:0]                   rsp_data,
    output logic [1:0]                           rsp_resp,
    output logic                                 rsp_write,
    output logic                                 timeout_err
);

    localparam int TW     = DATA_WD + ADDR_WD;
    localparam int GW     = $clog2(NUM_REQ);
    localparam int CNT_WD = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t              r_state;
    logic [GW-1:0]       r_grant;
    logic [GW-1:0]       r_last_grant;
    logic                r_is_write;
    logic [CNT_WD-1:0]   r_cnt;
    logic [NUM_REQ-1:0]  r_rsp_valid;
    logic [DATA_WD-1:0]  r_rsp_data;
    logic [1:0]          r_rsp_resp;
    logic                r_rsp_write;
    logic                r_timeout_err;

    logic [GW-1:0]       w_arb_grant;
    logic                w_any_req;
    logic [NUM_REQ-1:0]  w_grant_oh;
    logic [TW-1:0]       w_sel_data;
    logic [BYTE_WD-1:0]  w_sel_keep;
    logic                w_issue;
    logic                w_m_fire;
    logic                w_b_fire;
    logic                w_r_fire;
    logic                w_done;
    logic                w_timeout;

    rr_arbiter #(
        .N(NUM_REQ)
    ) u_arb (
        .req        (s_tvalid),
        .last_grant (r_last_grant),
        .grant      (w_arb_grant),
        .any_req    (w_any_req)
    );

    always_comb begin
        w_grant_oh = '0;
        w_sel_data = '0;
        w_sel_keep = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (GW'(i) == r_grant) begin
                w_grant_oh[i] = 1'b1;
                w_sel_data    = s_tdata[i*TW +: TW];
                w_sel_keep    = s_tkeep[i*BYTE_WD +: BYTE_WD];
            end
        end
    end

    assign w_issue  = (r_state == ISSUE);
    assign w_m_fire = w_issue && m_tready;
    assign w_b_fire = bvalid && bready;
    assign w_r_fire = rvalid && rready;
    // Only the channel matching the outstanding transaction counts as done.
    assign w_done    = r_is_write ? w_b_fire : w_r_fire;
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_WD'(TIMEOUT - 1));

    assign m_tvalid = w_issue;
    assign m_tdata  = w_issue ? w_sel_data : '0;
    assign m_tkeep  = w_issue ? w_sel_keep : '0;
    assign s_tready = w_m_fire ? w_grant_oh : '0;

    assign rsp_valid   = r_rsp_valid;
    assign rsp_data    = r_rsp_data;
    assign rsp_resp    = r_rsp_resp;
    assign rsp_write   = r_rsp_write;
    assign timeout_err = r_timeout_err;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= IDLE;
            r_grant       <= '0;
            r_last_grant  <= GW'(NUM_REQ - 1);
            r_is_write    <= 1'b0;
            r_cnt         <= '0;
            r_rsp_valid   <= '0;
            r_rsp_data    <= '0;
            r_rsp_resp    <= RESP_OKAY;
            r_rsp_write   <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_rsp_valid <= '0;
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_grant <= w_arb_grant;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (w_m_fire) begin
                        r_is_write <= is_write(MAX_KEEP'(w_sel_keep), BYTE_WD);
                        r_cnt      <= '0;
                        r_state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt != '1) r_cnt <= r_cnt + CNT_WD'(1);
                    if (w_done) begin
                        r_rsp_valid  <= w_grant_oh;
                        r_rsp_resp   <= r_is_write ? bresp : rresp;
                        r_rsp_data   <= r_is_write ? '0 : rdata;
                        r_rsp_write  <= r_is_write;
                        r_last_grant <= r_grant;
                        r_state      <= IDLE;
                    end else if (w_timeout) begin
                        // Rotation advances on timeout too, so a dead slave
                        // cannot pin priority on the same requester.
                        r_rsp_valid   <= w_grant_oh;
                        r_rsp_resp    <= RESP_SLVERR;
                        r_rsp_data    <= '0;
                        r_rsp_write   <= r_is_write;
                        r_last_grant  <= r_grant;
                        r_timeout_err <= 1'b1;
                        r_state       <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_done) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/axi_lite_req_scheduler.md
Name: axi_lite_req_scheduler

Overview:
- Shares one axi_lite_master stream port between NUM_REQ requesters using round-robin arbitration.
- Keeps exactly one transaction in flight. It watches (snoops) the AXI B and R channels and sends each completion back to the requester that issued it, as a tagged response pulse.
- Adds a response timeout, so a slave that never answers cannot stall the shared master.
- Sits between requester logic and the axi_lite_master stream input.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_WD, 8, AXI data width.
- ADDR_WD, 8, AXI address width.
- BYTE_WD, (ADDR_WD+DATA_WD)>>3, tkeep width per stream beat.
- TIMEOUT, 255, WAIT-state cycle limit; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- s_tkeep  in  NUM_REQ*BYTE_WD  per-requester tkeep; all ones = write, otherwise read
- s_tdata  in  NUM_REQ*(DATA_WD+ADDR_WD)  per-requester {wdata, addr}
- s_tvalid  in  NUM_REQ  request valid
- s_tready  out  NUM_REQ  request accepted
- m_tkeep  out  BYTE_WD  to axi_lite_master
- m_tdata  out  DATA_WD+ADDR_WD  to axi_lite_master
- m_tvalid  out  1  to axi_lite_master
- m_tready  in  1  from axi_lite_master
- bvalid, bready  in  1 each  snooped write-response handshake
- bresp  in  2  snooped write response
- rvalid, rready  in  1 each  snooped read-data handshake
- rdata  in  DATA_WD  snooped read data
- rresp  in  2  snooped read response
- rsp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse
- rsp_data  out  DATA_WD  read data (0 for writes and timeouts)
- rsp_resp  out  2  bresp/rresp, or 2'b10 on timeout
- rsp_write  out  1  1 = completion of a write
- timeout_err  out  1  sticky; cleared only by reset

Behaviour:
- Reset values:
  - all outputs 0
  - FSM = IDLE
  - last_grant = NUM_REQ-1, so requester 0 has first priority
  - timeout counter = 0
- An asynchronous reset during any state aborts tracking. Any response still in flight afterwards is ignored, because the FSM is in IDLE.
- FSM states: IDLE, ISSUE, WAIT, DRAIN.
- IDLE:
  - If any s_tvalid is set, register grant = the first set bit searching from last_grant+1, wrapping modulo NUM_REQ. Go to ISSUE.
  - s_tready = 0. m_tvalid = 0.
- ISSUE:
  - m_tvalid = 1; m_tkeep and m_tdata are muxed from the granted requester.
  - s_tready[grant] = m_tready; all other s_tready bits = 0.
  - m_fire = m_tvalid && m_tready. On m_fire: latch is_write = &m_tkeep, clear the counter, go to WAIT.
  - If the requester drops s_tvalid before m_fire (protocol violation), that is not supported. The bench flags it as an error.
- WAIT:
  - Write completion is bvalid&&bready when is_write. Read completion is rvalid&&rready when !is_write. A handshake on the other channel is ignored.
  - On completion, in the next cycle:
    - rsp_valid[grant] = 1
    - rsp_resp = bresp or rresp
    - rsp_data = rdata (read) or 0 (write)
    - rsp_write = is_write
    - last_grant = grant
    - FSM returns to IDLE
  - The counter increments each WAIT cycle, saturating. If TIMEOUT != 0 and counter == TIMEOUT-1 without completion:
    - pulse rsp_valid[grant] with rsp_resp = 2'b10 and rsp_data = 0
    - set timeout_err
    - go to DRAIN
  - If completion and timeout occur in the same cycle, completion wins.
- DRAIN: wait for the late completion of the matching type, discard it, go to IDLE. There is no timeout in DRAIN.
- Latency:
  - s_tvalid rising in IDLE at cycle 0 gives m_tvalid at cycle 1.
  - A completion fire at cycle N gives rsp_valid at cycle N+1.
  - The earliest next grant is registered at cycle N+2.
- rsp_data, rsp_resp and rsp_write hold their values until the next pulse.
- Fairness: each requester waits at most NUM_REQ-1 transactions before it is granted.
- Width rules:
  - requester i occupies s_tdata[i*(DATA_WD+ADDR_WD) +: DATA_WD+ADDR_WD] and s_tkeep[i*BYTE_WD +: BYTE_WD]
  - grant index width = $clog2(NUM_REQ)

Decomposition:
- Shared package axi_lite_pkg holds:
  - the response codes RESP_OKAY=2'b00 and RESP_SLVERR=2'b10
  - the FSM state typedef {IDLE, ISSUE, WAIT, DRAIN}
  - the function is_write(tkeep)
- Sub-module rr_arbiter (parameter N):
  - inputs: req[N], last_grant
  - outputs: grant index and any_req
  - purely combinational, reusable by other masters

Test Plan:
- Single write from req1 (tdata={8'hA5, 8'h10}, tkeep=2'b11); bresp=00 three cycles after m_fire -> m_tdata=16'hA510; rsp_valid=4'b0010 one cycle with rsp_write=1, rsp_resp=00.
- Single read from req2 (addr 8'h20, tkeep=2'b01); slave returns rdata=8'h5C -> rsp_valid=4'b0100, rsp_data=8'h5C, rsp_write=0.
- All four requesters hold s_tvalid continuously -> grants in order 0,1,2,3,0; each requester receives exactly one rsp_valid per round.
- Bursty backpressure: m_tready low for 5 cycles in ISSUE -> m_tvalid and m_tdata stay stable and no s_tready pulses; accepted on the 6th cycle.
- TIMEOUT=8 with no bvalid -> rsp_resp=2'b10 pulse 8 WAIT cycles after m_fire and timeout_err=1; a late bvalid&&bready at cycle 20 is discarded (no rsp_valid), then IDLE.
- Reset asserted in WAIT -> all outputs 0 and state IDLE; a subsequent rvalid&&rready produces no rsp_valid; the next request goes to req0.
